// File: rtl/vec_alu_sequencer.sv
// vec_alu_sequencer: accepts one whole-register vector op, slices the operands
// into lane-sized chunks issued beat by beat across up to four lanes, gathers
// the registered lane results into a VLEN-bit image and holds it for writeback.
module vec_alu_sequencer #(
  parameter int VLEN       = 128,
  parameter int LANE_WIDTH = 4,
  parameter int NB_LANES   = 0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [5:0]                  opcode,
  input  logic [2:0]                  vsew,
  input  logic [VLEN-1:0]             vs1,
  input  logic [VLEN-1:0]             vs2,
  output logic                        busy,
  output logic                        err,
  output logic [3:0]                  run,
  output logic [5:0]                  lane_op,
  output logic [2:0]                  lane_sew,
  output logic [3:0]                  lane_first,
  output logic [(4<<LANE_WIDTH)-1:0]  lane_a,
  output logic [(4<<LANE_WIDTH)-1:0]  lane_b,
  input  logic [(4<<LANE_WIDTH)-1:0]  lane_res,
  output logic [VLEN-1:0]             vd,
  output logic                        out_valid,
  input  logic                        out_ready
);

  localparam int LW      = 1 << LANE_WIDTH;
  localparam int LG_VLEN = $clog2(VLEN);
  // Worst case is one lane with 8-bit chunks: VLEN/8 beats.
  localparam int BEAT_W  = LG_VLEN - 2;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_HOLD} state_t;

  state_t              state_q;
  logic [BEAT_W-1:0]   beat_q;
  logic [5:0]          op_q;
  logic [2:0]          sew_q;
  logic                err_q;
  logic [VLEN-1:0]     vs1_q, vs2_q;
  logic [VLEN-1:0]     vd_q, vd_d;
  logic [3:0]          col_run_q;
  logic [3:0][31:0]    col_off_q;
  logic [3:0][31:0]    iss_off;
  logic                accept;

  // Operation geometry, all as log2 so divides/mods become shifts/masks.
  logic [31:0] lg_sew, lg_cw, lg_k, lg_e, lg_l, lg_b, last_beat;
  logic [31:0] grp, part, off;
  logic [LW-1:0] cw_mask;

  // Mask covering the low CW bits of a lane word (all ones when CW == LW).
  function automatic logic [LW-1:0] chunk_mask(input logic [31:0] lg_w);
    return {LW{1'b1}} >> (32'(LW) - (32'd1 << lg_w));
  endfunction

  // Derive chunk width, chunks/element, active lanes and beat count from latched SEW.
  always_comb begin
    lg_sew    = 32'd3 + 32'(sew_q);
    lg_cw     = (lg_sew < 32'(LANE_WIDTH)) ? lg_sew : 32'(LANE_WIDTH);
    lg_k      = lg_sew - lg_cw;
    lg_e      = 32'(LG_VLEN) - lg_sew;
    lg_l      = (lg_e < 32'(NB_LANES)) ? lg_e : 32'(NB_LANES);
    lg_b      = lg_e - lg_l + lg_k;
    last_beat = (32'd1 << lg_b) - 32'd1;
    cw_mask   = chunk_mask(lg_cw);
  end

  assign accept = (state_q == S_IDLE) && start && (vsew <= 3'd3);

  // Issue decode: map the current beat onto per-lane element chunks.
  always_comb begin
    run        = '0;
    lane_first = '0;
    lane_a     = '0;
    lane_b     = '0;
    iss_off    = '0;
    grp        = 32'(beat_q) >> lg_k;
    part       = 32'(beat_q) & ((32'd1 << lg_k) - 32'd1);
    off        = '0;
    if (state_q == S_ISSUE) begin
      for (int i = 0; i < 4; i++) begin
        if (32'(i) < (32'd1 << lg_l)) begin
          off                  = (((grp << lg_l) + 32'(i)) << lg_sew) + (part << lg_cw);
          run[i]               = 1'b1;
          lane_first[i]        = (part == 32'd0);
          lane_a[i*LW +: LW]   = LW'(vs1_q >> off) & cw_mask;
          lane_b[i*LW +: LW]   = LW'(vs2_q >> off) & cw_mask;
          iss_off[i]           = off;
        end
      end
    end
  end

  // Collect: merge the previous beat's lane results into the destination image.
  always_comb begin
    vd_d = vd_q;
    for (int i = 0; i < 4; i++) begin
      if (col_run_q[i]) begin
        vd_d = (vd_d & ~(VLEN'(cw_mask) << col_off_q[i]))
             | (VLEN'(lane_res[i*LW +: LW] & cw_mask) << col_off_q[i]);
      end
    end
  end

  // Control FSM: accept, beat sequencing, drain of the last beat, hold for writeback.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      beat_q    <= '0;
      op_q      <= '0;
      sew_q     <= '0;
      err_q     <= 1'b0;
      vd_q      <= '0;
      col_run_q <= '0;
    end else begin
      err_q     <= 1'b0;
      col_run_q <= run;
      vd_q      <= vd_d;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            if (vsew > 3'd3) begin
              err_q <= 1'b1;
            end else begin
              op_q    <= opcode;
              sew_q   <= vsew;
              vd_q    <= '0;
              beat_q  <= '0;
              state_q <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          beat_q <= beat_q + BEAT_W'(1);
          if (32'(beat_q) == last_beat) state_q <= S_DRAIN;
        end
        S_DRAIN: state_q <= S_HOLD;
        S_HOLD:  if (out_ready) state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Operand capture and issued-beat offsets (data only, qualified by control).
  always_ff @(posedge clk) begin
    if (accept) begin
      vs1_q <= vs1;
      vs2_q <= vs2;
    end
    col_off_q <= iss_off;
  end

  assign busy      = (state_q != S_IDLE);
  assign out_valid = (state_q == S_HOLD);
  assign err       = err_q;
  assign lane_op   = op_q;
  assign lane_sew  = sew_q;
  assign vd        = vd_q;

endmodule
